// File: rtl/lap_pkg.sv
// lap_pkg: shared types and constants for the lap/split memory controller.
// Contents: lap_state_t (controller states), SRC_* display-source codes,
//           bcd_time_t (eight BCD digits, hours tens in the top nibble).
package lap_pkg;
    typedef enum logic [1:0] {LIVE, HOLD, RECALL} lap_state_t;
    localparam logic [1:0] SRC_LIVE   = 2'd0;
    localparam logic [1:0] SRC_HOLD   = 2'd1;
    localparam logic [1:0] SRC_RECALL = 2'd2;
    typedef struct packed {
        logic [3:0] d_h, u_h, d_m, u_m, d_s, u_s, d_cs, u_cs;
    } bcd_time_t;
endpackage

// File: rtl/lap_ram.sv
// lap_ram: DEPTH x 32 lap storage, one synchronous write port and one registered read port, no reset.
// Ports: clock; we/waddr/wdata write port; raddr read address; rdata registered read data.
module lap_ram
    import lap_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  bcd_time_t     wdata,
    input  logic [IW-1:0] raddr,
    output bcd_time_t     rdata
);
    bcd_time_t mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/lap_memory_ctrl.sv
// lap_memory_ctrl: captures split times into a lap ring, freezes them on the display, and browses stored laps.
// Ports: clock, reset (async, active-high); tick_cs centisecond enable; run stopwatch running;
//        lap_pulse / recall_pulse / clear_pulse button events; time_in live BCD time;
//        disp_out BCD time to display; disp_src 0 live / 1 hold / 2 recall; lap_index age of recalled lap;
//        lap_count stored laps (saturating); full lap_count == DEPTH.
// Build option: define LAP_OVERWRITE_EN to let a lap taken while full overwrite the oldest entry;
//               otherwise such a lap is ignored.
module lap_memory_ctrl
    import lap_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int HOLD_TICKS = 50
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      tick_cs,
    input  logic                      run,
    input  logic                      lap_pulse,
    input  logic                      recall_pulse,
    input  logic                      clear_pulse,
    input  logic [31:0]               time_in,
    output logic [31:0]               disp_out,
    output logic [1:0]                disp_src,
    output logic [$clog2(DEPTH)-1:0]  lap_index,
    output logic [$clog2(DEPTH):0]    lap_count,
    output logic                      full
);
    localparam int IW = $clog2(DEPTH);
    localparam int HW = $clog2(HOLD_TICKS + 1);
`ifdef LAP_OVERWRITE_EN
    localparam bit OVERWRITE = 1'b1;
`else
    localparam bit OVERWRITE = 1'b0;
`endif

    lap_state_t    state, state_n;
    logic [IW-1:0] wr_ptr, wr_ptr_n, idx, idx_n, rd_addr;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [IW:0]   count_n;
    logic          capture, clear, can_cap;
    bcd_time_t     disp_r, disp_n, rd_data;

    always_comb begin
        state_n  = state;
        wr_ptr_n = wr_ptr;
        idx_n    = idx;
        hold_n   = hold_cnt;
        count_n  = lap_count;
        capture  = 1'b0;
        clear    = 1'b0;
        can_cap  = run && (!full || OVERWRITE);
        if (state == LIVE) begin
            if (clear_pulse && !run) clear = 1'b1;
            else if (lap_pulse && can_cap) capture = 1'b1;
            else if (recall_pulse && !run && lap_count != '0) begin
                state_n = RECALL;
                idx_n   = '0;
            end
        end else if (state == HOLD) begin
            if (lap_pulse && can_cap) capture = 1'b1;
            else if (tick_cs) begin
                state_n = (hold_cnt == HW'(HOLD_TICKS - 1)) ? LIVE : HOLD;
                hold_n  = (hold_cnt == HW'(HOLD_TICKS - 1)) ? '0 : hold_cnt + HW'(1);
            end
        end else begin
            if (clear_pulse || lap_pulse || run) begin
                clear   = clear_pulse;
                state_n = LIVE;
                idx_n   = '0;
            end else if (recall_pulse)
                idx_n = ({1'b0, idx} == lap_count - (IW+1)'(1)) ? '0 : idx + IW'(1);
        end
        if (clear) begin
            count_n  = '0;
            wr_ptr_n = '0;
        end
        if (capture) begin
            state_n  = HOLD;
            hold_n   = '0;
            wr_ptr_n = wr_ptr + IW'(1);
            count_n  = full ? lap_count : lap_count + (IW+1)'(1);
        end
        // Frozen value lives in disp_r; it only reloads on capture or outside HOLD.
        disp_n  = (state_n == HOLD && !capture) ? disp_r : bcd_time_t'(time_in);
        // Address from next-state pointers so the RAM output lines up with the RECALL cycle.
        rd_addr = wr_ptr_n - IW'(1) - idx_n;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= LIVE;
            wr_ptr    <= '0;
            idx       <= '0;
            hold_cnt  <= '0;
            lap_count <= '0;
            full      <= 1'b0;
            disp_r    <= '0;
        end else begin
            state     <= state_n;
            wr_ptr    <= wr_ptr_n;
            idx       <= idx_n;
            hold_cnt  <= hold_n;
            lap_count <= count_n;
            full      <= (count_n == (IW+1)'(DEPTH));
            disp_r    <= disp_n;
        end
    end

    lap_ram #(.DEPTH(DEPTH), .IW(IW)) u_ram (
        .clock (clock),
        .we    (capture),
        .waddr (wr_ptr),
        .wdata (bcd_time_t'(time_in)),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign disp_out  = (state == RECALL) ? rd_data : disp_r;
    assign disp_src  = (state == HOLD) ? SRC_HOLD : (state == RECALL) ? SRC_RECALL : SRC_LIVE;
    assign lap_index = idx;
endmodule

// File: tb/tb_lap_memory_ctrl.sv
// tb_lap_memory_ctrl: directed self-checking bench for lap_memory_ctrl (DEPTH=8, HOLD_TICKS=50).
module tb_lap_memory_ctrl;
    logic        clock = 1'b0, reset = 1'b1, tick_cs = 1'b0, run = 1'b0;
    logic        lap_pulse = 1'b0, recall_pulse = 1'b0, clear_pulse = 1'b0;
    logic [31:0] time_in = '0, disp_out;
    logic [1:0]  disp_src;
    logic [2:0]  lap_index;
    logic [3:0]  lap_count;
    logic        full;
    int          tests = 0, fails = 0;

    lap_memory_ctrl #(.DEPTH(8), .HOLD_TICKS(50)) dut (
        .clock        (clock),
        .reset        (reset),
        .tick_cs      (tick_cs),
        .run          (run),
        .lap_pulse    (lap_pulse),
        .recall_pulse (recall_pulse),
        .clear_pulse  (clear_pulse),
        .time_in      (time_in),
        .disp_out     (disp_out),
        .disp_src     (disp_src),
        .lap_index    (lap_index),
        .lap_count    (lap_count),
        .full         (full)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
        lap_pulse    = 1'b0;
        recall_pulse = 1'b0;
        clear_pulse  = 1'b0;
        tick_cs      = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_cs = 1'b1;
            cyc();
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_disp"}, disp_out, 32'h0);
        check({tag, "_src"}, {30'b0, disp_src}, 32'd0);
        check({tag, "_idx"}, {29'b0, lap_index}, 32'd0);
        check({tag, "_cnt"}, {28'b0, lap_count}, 32'd0);
        check({tag, "_full"}, {31'b0, full}, 32'd0);
    endtask

    task automatic recall_check(input string tag, input logic [31:0] exp_disp, input logic [2:0] exp_idx);
        recall_pulse = 1'b1;
        cyc();
        check({tag, "_src"}, {30'b0, disp_src}, 32'd2);
        check({tag, "_disp"}, disp_out, exp_disp);
        check({tag, "_idx"}, {29'b0, lap_index}, {29'b0, exp_idx});
    endtask

    initial begin
        cyc();
        cyc();
        check_reset("reset");
        reset = 1'b0;
        time_in = 32'h42;
        lap_pulse = 1'b1;
        cyc();
        check("lap_stopped_src", {30'b0, disp_src}, 32'd0);
        check("live_delay", disp_out, 32'h42);
        check("lap_stopped_cnt", {28'b0, lap_count}, 32'd0);

        run = 1'b1;
        time_in = 32'h00012345;
        lap_pulse = 1'b1;
        cyc();
        check("cap_src", {30'b0, disp_src}, 32'd1);
        check("cap_disp", disp_out, 32'h00012345);
        check("cap_cnt", {28'b0, lap_count}, 32'd1);
        time_in = 32'h00099999;
        ticks(49);
        check("hold49_src", {30'b0, disp_src}, 32'd1);
        check("hold49_disp", disp_out, 32'h00012345);
        ticks(1);
        check("hold50_src", {30'b0, disp_src}, 32'd0);
        check("hold50_disp", disp_out, 32'h00099999);
        time_in = 32'h55;
        cyc();
        check("live_track", disp_out, 32'h55);

        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            time_in = 32'h100 * i;
            lap_pulse = 1'b1;
            cyc();
        end
        check("three_cnt", {28'b0, lap_count}, 32'd3);
        ticks(50);
        recall_pulse = 1'b1;
        cyc();
        check("recall_running_src", {30'b0, disp_src}, 32'd0);
        run = 1'b0;
        recall_check("rc0", 32'h300, 3'd0);
        recall_check("rc1", 32'h200, 3'd1);
        recall_check("rc2", 32'h100, 3'd2);
        recall_check("rc3", 32'h300, 3'd0);

        reset = 1'b1;
        cyc();
        check_reset("reset_recall");
        reset = 1'b0;
        recall_pulse = 1'b1;
        cyc();
        check("recall_empty_src", {30'b0, disp_src}, 32'd0);

        run = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            time_in = i;
            lap_pulse = 1'b1;
            cyc();
            ticks(50);
        end
        check("full8_cnt", {28'b0, lap_count}, 32'd8);
        check("full8_full", {31'b0, full}, 32'd1);
        time_in = 32'd9;
        lap_pulse = 1'b1;
        cyc();
`ifdef LAP_OVERWRITE_EN
        check("lap9_src", {30'b0, disp_src}, 32'd1);
`else
        check("lap9_src", {30'b0, disp_src}, 32'd0);
`endif
        check("lap9_disp", disp_out, 32'd9);
        check("lap9_cnt", {28'b0, lap_count}, 32'd8);
        check("lap9_full", {31'b0, full}, 32'd1);
        ticks(50);
        run = 1'b0;
`ifdef LAP_OVERWRITE_EN
        recall_check("newest", 32'd9, 3'd0);
`else
        recall_check("newest", 32'd8, 3'd0);
`endif
        for (int i = 0; i < 6; i++) begin
            recall_pulse = 1'b1;
            cyc();
        end
`ifdef LAP_OVERWRITE_EN
        recall_check("oldest", 32'd2, 3'd7);
`else
        recall_check("oldest", 32'd1, 3'd7);
`endif

        run = 1'b1;
        cyc();
        check("run_exit_src", {30'b0, disp_src}, 32'd0);
        check("run_exit_idx", {29'b0, lap_index}, 32'd0);
        run = 1'b0;
        clear_pulse = 1'b1;
        recall_pulse = 1'b1;
        cyc();
        check("clr_cnt", {28'b0, lap_count}, 32'd0);
        check("clr_full", {31'b0, full}, 32'd0);
        check("clr_src", {30'b0, disp_src}, 32'd0);
        recall_pulse = 1'b1;
        cyc();
        check("clr_recall_src", {30'b0, disp_src}, 32'd0);

        run = 1'b1;
        time_in = 32'hA1;
        lap_pulse = 1'b1;
        cyc();
        ticks(30);
        check("hold30_disp", disp_out, 32'hA1);
        time_in = 32'hB2;
        lap_pulse = 1'b1;
        cyc();
        check("relap_disp", disp_out, 32'hB2);
        check("relap_cnt", {28'b0, lap_count}, 32'd2);
        time_in = 32'hC3;
        ticks(49);
        check("relap49_src", {30'b0, disp_src}, 32'd1);
        check("relap49_disp", disp_out, 32'hB2);
        ticks(1);
        check("relap50_src", {30'b0, disp_src}, 32'd0);
        check("relap50_disp", disp_out, 32'hC3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/lap_memory_ctrl.md
# lap_memory_ctrl

Lap/split memory controller for the stopwatch. It captures the live BCD time into a DEPTH-entry lap buffer whenever split is pressed while running, and freezes the captured value on the display for a fixed number of centisecond ticks. When the stopwatch is stopped, the operator can browse the stored laps. The block sits between the main stopwatch FSM / time counters and the 8-digit display driver, and sequences what the display shows.

## Interface
Parameters:
- DEPTH, 8: number of lap entries; power of two, ≥2. IW = $clog2(DEPTH).
- HOLD_TICKS, 50: number of tick_cs pulses a freshly captured lap stays frozen on the display; ≥1.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- tick_cs  in  1  one-cycle enable pulse per centisecond, synchronous to clock.
- run  in  1  high while the stopwatch is counting.
- lap_pulse  in  1  one-cycle pulse from the edge-detected split button.
- recall_pulse  in  1  one-cycle pulse from the edge-detected browse button.
- clear_pulse  in  1  one-cycle pulse that erases the lap buffer.
- time_in  in  32  live BCD time {d_h,u_h,d_m,u_m,d_s,u_s,d_cs,u_cs}, one nibble per digit.
- disp_out  out  32  BCD time to the display driver, same packing as time_in.
- disp_src  out  2  display source: 0 = LIVE, 1 = HOLD (frozen lap), 2 = RECALL.
- lap_index  out  IW  age of the recalled lap: 0 = newest. Reads 0 outside RECALL.
- lap_count  out  IW+1  number of stored laps, saturates at DEPTH.
- full  out  1  high when lap_count == DEPTH.

## Operation
- States: LIVE, HOLD, RECALL. Priority for simultaneous pulses: clear_pulse > lap_pulse > recall_pulse.
- LIVE: disp_out follows time_in.
  - lap_pulse with run=1: the block writes time_in into mem[wr_ptr], increments wr_ptr modulo DEPTH, increments lap_count (saturating), latches time_in as the frozen value, clears the hold counter, and moves to HOLD.
  - lap_pulse with run=0 is ignored.
  - recall_pulse with run=0 and lap_count>0: move to RECALL with index 0. recall_pulse with lap_count=0 or run=1 is ignored.
  - clear_pulse with run=0: lap_count=0, wr_ptr=0. With run=1 it is ignored.
- HOLD: disp_out shows the frozen value.
  - The hold counter increments on each tick_cs. On the HOLD_TICKS-th tick the block returns to LIVE. A tick in the entry cycle is not counted.
  - lap_pulse (run=1) captures a new lap and restarts the hold count; the block stays in HOLD.
  - recall_pulse and clear_pulse are ignored.
  - If run falls during HOLD, the hold still completes normally.
- RECALL: disp_out = mem[(wr_ptr-1-index) mod DEPTH].
  - recall_pulse increments index. When index reaches lap_count-1, the next recall_pulse wraps it to 0.
  - lap_pulse exits to LIVE without capturing.
  - run=1 exits to LIVE.
  - clear_pulse clears the buffer and exits to LIVE.
- Full buffer: see Configuration.

## Timing
- All outputs are registered. Every output reflects an input or event one clock after the event cycle.
- In LIVE, disp_out equals time_in delayed by one clock.
- Lap RAM: synchronous write, registered read. The recall read address is computed combinationally from the next-state index, so disp_out is valid one clock after the recall_pulse or RECALL entry.
- On capture, lap_count and full update in the cycle after lap_pulse. In that same cycle disp_src becomes 1 and disp_out shows the captured time.
- Reset values: state LIVE, wr_ptr 0, index 0, hold counter 0, lap_count 0, full 0, disp_out 0, disp_src 0, lap_index 0. RAM contents are not reset; they are unreadable while lap_count=0.
- Reset asserted mid-HOLD or mid-RECALL returns the block to LIVE immediately and loses all stored laps.

## Configuration
- LAP_OVERWRITE_EN defined: a lap_pulse while full overwrites the oldest entry (ring buffer). lap_count stays DEPTH and the block enters HOLD.
- LAP_OVERWRITE_EN undefined: a lap_pulse while full is ignored entirely. No write occurs, the state stays LIVE, and pointers are unchanged.

## Structure
- Package lap_pkg holds:
  - lap_state_t enum (LIVE, HOLD, RECALL);
  - disp_src constants SRC_LIVE=0, SRC_HOLD=1, SRC_RECALL=2;
  - bcd_time_t packed struct of eight 4-bit digits matching the time_in packing.
- Sub-module lap_ram: DEPTH×32, one write port and one registered read port, no reset.

## Test plan
- Reset, then run=1, time_in=0x00012345, lap_pulse → next cycle: disp_src=1, disp_out=0x00012345, lap_count=1. After exactly 50 tick_cs: disp_src=0, disp_out tracks time_in.
- Three laps 0x100, 0x200, 0x300, then run=0 and recall_pulse ×4 → disp_out sequence 0x300, 0x200, 0x100, 0x300; lap_index sequence 0, 1, 2, 0.
- DEPTH=8 with 9 laps, values 1..9:
  - with LAP_OVERWRITE_EN: full=1, lap_count=8, oldest recalled lap = 2;
  - without it: the 9th pulse leaves disp_src=0 and the oldest recalled lap = 1.
- Same-cycle clear_pulse and recall_pulse with run=0 → lap_count=0, state LIVE. A subsequent recall_pulse is ignored.
- lap_pulse in HOLD after 30 ticks → new value frozen; LIVE resumes only after 50 further ticks.
- Assert reset during RECALL → the next cycle shows all outputs at their reset values and lap_count=0.
